// File: rtl/dsi_hs_lane_rx_if.sv
// dsi_hs_lane_rx_if: lane-side bundle of the D-PHY HS receive lane.
// The master modport is the deserializer/LP-control side that drives the lane
// inputs and collects the aligned byte stream. The slave modport is the
// receive lane itself.
interface dsi_hs_lane_rx_if;
    logic       hs_rx_en;
    logic [7:0] serdes_data;
    logic [7:0] hs_sync_timeout;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_sop;
    logic       rx_active;
    logic       sot_err;

    modport master (
        output hs_rx_en,
        output serdes_data,
        output hs_sync_timeout,
        input  rx_data,
        input  rx_valid,
        input  rx_sop,
        input  rx_active,
        input  sot_err
    );

    modport slave (
        input  hs_rx_en,
        input  serdes_data,
        input  hs_sync_timeout,
        output rx_data,
        output rx_valid,
        output rx_sop,
        output rx_active,
        output sot_err
    );
endinterface

// File: rtl/dsi_hs_lane_rx.sv
// dsi_hs_lane_rx: MIPI D-PHY HS receive lane.
// Looks for the SoT sync byte at any of 8 bit offsets in a two-byte window of
// deserialized data, then emits byte-aligned payload one byte per clock until
// hs_rx_en drops. A sync pattern seen after lock is ordinary payload.
// Optional build macro: DSI_HS_RX_SOT_TOLERANT_EN -- also lock on a sync byte
// with a single bit error (flagged on sot_err); exact matches take priority.
module dsi_hs_lane_rx (
    input  logic                    clk,
    input  logic                    rst_n,
    dsi_hs_lane_rx_if.slave         rx_if
);

    localparam logic [7:0] SYNC_BYTE = 8'b1011_1000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        ACTIVE = 2'd2,
        ERROR  = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] d0_q, d1_q;
    logic [2:0] offset_q, offset_d;
    logic [7:0] cnt_q, cnt_d;
    logic       sop_pend_q, sop_pend_d;

    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       rx_sop_q, rx_sop_d;
    logic       rx_active_q, rx_active_d;
    logic       sot_err_q, sot_err_d;

    // Two-byte window: d1 is older, so it sits in the low (earlier) bits.
    logic [15:0] win;
    assign win = {d0_q, d1_q};

    // Per-offset exact compare of the window against the sync byte.
    logic [7:0] exact_hit;
    for (genvar k = 0; k < 8; k++) begin : g_exact
        assign exact_hit[k] = (win[k +: 8] == SYNC_BYTE);
    end

    logic       exact_any;
    logic [2:0] exact_idx;

    // Lowest matching offset wins.
    always_comb begin
        exact_any = 1'b0;
        exact_idx = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (exact_hit[k]) begin
                exact_any = 1'b1;
                exact_idx = 3'(k);
            end
        end
    end

    logic       lock_any;
    logic [2:0] lock_idx;
    logic       lock_soft;

`ifdef DSI_HS_RX_SOT_TOLERANT_EN
    // Single-bit-error compare: the XOR with the sync byte is a power of two.
    logic [7:0] near_hit;
    for (genvar k = 0; k < 8; k++) begin : g_near
        logic [7:0] diff;
        assign diff        = win[k +: 8] ^ SYNC_BYTE;
        assign near_hit[k] = (diff != 8'd0) && ((diff & (diff - 8'd1)) == 8'd0);
    end

    logic       near_any;
    logic [2:0] near_idx;

    // Lowest offset with a one-bit error, used only when no exact match exists.
    always_comb begin
        near_any = 1'b0;
        near_idx = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (near_hit[k]) begin
                near_any = 1'b1;
                near_idx = 3'(k);
            end
        end
    end

    assign lock_any  = exact_any | near_any;
    assign lock_idx  = exact_any ? exact_idx : near_idx;
    assign lock_soft = ~exact_any & near_any;
`else
    assign lock_any  = exact_any;
    assign lock_idx  = exact_idx;
    assign lock_soft = 1'b0;
`endif

    // Raw byte pipeline feeding the search window; runs regardless of state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d0_q <= 8'd0;
            d1_q <= 8'd0;
        end else begin
            d0_q <= rx_if.serdes_data;
            d1_q <= d0_q;
        end
    end

    // Next state and registered outputs; hs_rx_en low overrides every state.
    always_comb begin
        state_d    = state_q;
        offset_d   = offset_q;
        cnt_d      = cnt_q;
        sop_pend_d = sop_pend_q;
        rx_data_d  = 8'd0;
        rx_valid_d = 1'b0;
        rx_sop_d   = 1'b0;
        sot_err_d  = 1'b0;

        if (!rx_if.hs_rx_en) begin
            state_d    = IDLE;
            offset_d   = 3'd0;
            cnt_d      = 8'd0;
            sop_pend_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = SEARCH;
                    cnt_d   = rx_if.hs_sync_timeout;
                end
                SEARCH: begin
                    if (lock_any) begin
                        state_d    = ACTIVE;
                        offset_d   = lock_idx;
                        sop_pend_d = 1'b1;
                        cnt_d      = 8'd0;
                        sot_err_d  = lock_soft;
                    end else if (cnt_q == 8'd1) begin
                        // Last budgeted byte searched without a match.
                        state_d   = ERROR;
                        cnt_d     = 8'd0;
                        sot_err_d = 1'b1;
                    end else if (cnt_q != 8'd0) begin
                        // A loaded value of 0 leaves the counter parked: no timeout.
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                ACTIVE: begin
                    rx_data_d  = win[offset_q +: 8];
                    rx_valid_d = 1'b1;
                    rx_sop_d   = sop_pend_q;
                    sop_pend_d = 1'b0;
                end
                ERROR: begin
                    state_d = ERROR;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        rx_active_d = (state_d == ACTIVE);
    end

    // State, alignment and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            offset_q    <= 3'd0;
            cnt_q       <= 8'd0;
            sop_pend_q  <= 1'b0;
            rx_data_q   <= 8'd0;
            rx_valid_q  <= 1'b0;
            rx_sop_q    <= 1'b0;
            rx_active_q <= 1'b0;
            sot_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            offset_q    <= offset_d;
            cnt_q       <= cnt_d;
            sop_pend_q  <= sop_pend_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            rx_sop_q    <= rx_sop_d;
            rx_active_q <= rx_active_d;
            sot_err_q   <= sot_err_d;
        end
    end

    assign rx_if.rx_data   = rx_data_q;
    assign rx_if.rx_valid  = rx_valid_q;
    assign rx_if.rx_sop    = rx_sop_q;
    assign rx_if.rx_active = rx_active_q;
    assign rx_if.sot_err   = sot_err_q;

endmodule

// File: tb/tb_dsi_hs_lane_rx.sv
// tb_dsi_hs_lane_rx: directed bench for the HS receive lane.
// Inputs are driven on the falling edge; outputs are read on the same falling
// edge just before new inputs are applied, so each read reflects all rising
// edges so far. Bit 0 of every byte is the earliest bit on the wire.
module tb_dsi_hs_lane_rx;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    dsi_hs_lane_rx_if lane();

    dsi_hs_lane_rx dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rx_if (lane.slave)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] d, input logic v,
                           input logic s, input logic a, input logic e);
        chk({tag, ".data"},   32'(lane.rx_data),   32'(d));
        chk({tag, ".valid"},  32'(lane.rx_valid),  32'(v));
        chk({tag, ".sop"},    32'(lane.rx_sop),    32'(s));
        chk({tag, ".active"}, 32'(lane.rx_active), 32'(a));
        chk({tag, ".soterr"}, 32'(lane.sot_err),   32'(e));
    endtask

    // One byte clock: wait for the falling edge, then present en/byte.
    task automatic cyc(input logic en, input logic [7:0] b);
        @(negedge clk);
        lane.hs_rx_en    = en;
        lane.serdes_data = b;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic seen_err;
        logic seen_act;

        lane.hs_rx_en        = 1'b0;
        lane.serdes_data     = 8'h00;
        lane.hs_sync_timeout = 8'd0;

        // Reset values.
        #12;
        chk_out("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b0, 8'h00);
        cyc(1'b0, 8'h00);

        // Aligned sync (offset 0): sync sits entirely in the older byte.
        cyc(1'b1, 8'h00);
        cyc(1'b1, 8'h00);
        cyc(1'b1, 8'hB8);
        cyc(1'b1, 8'h12);
        cyc(1'b1, 8'h34);
        chk("algn.pre_active", 32'(lane.rx_active), 32'd0);
        cyc(1'b1, 8'h56);
        chk_out("algn.lock", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 8'h78);
        chk_out("algn.b0", 8'h12, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 8'h9A);
        chk_out("algn.b1", 8'h34, 1'b1, 1'b0, 1'b1, 1'b0);

        // Abort mid-packet: enable drops, outputs idle after the next edge.
        cyc(1'b0, 8'h00);
        chk_out("abort.last", 8'h56, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 8'h00);
        chk_out("abort.idle", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Re-sync at offset 3: 11 zero bits, sync, payload 0xA5.
        cyc(1'b1, 8'h00);
        cyc(1'b1, 8'hC0);
        cyc(1'b1, 8'h2D);
        cyc(1'b1, 8'h05);
        cyc(1'b1, 8'h00);
        chk_out("off3.lock", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 8'h00);
        chk_out("off3.b0", 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 8'h00);
        chk_out("off3.b1", 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);

        // Timeout after 4 searched bytes, then ERROR ignores a sync pattern.
        cyc(1'b0, 8'h00);
        cyc(1'b0, 8'h00);
        lane.hs_sync_timeout = 8'd4;
        cyc(1'b1, 8'h00);
        cyc(1'b1, 8'h00);
        cyc(1'b1, 8'h00);
        cyc(1'b1, 8'h00);
        cyc(1'b1, 8'h00);
        chk("tmo.before", 32'(lane.sot_err), 32'd0);
        cyc(1'b1, 8'hB8);
        chk_out("tmo.pulse", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 8'h12);
        chk("tmo.one_cycle", 32'(lane.sot_err), 32'd0);
        cyc(1'b1, 8'h34);
        cyc(1'b0, 8'h00);
        chk_out("tmo.err_hold", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 8'h00);
        cyc(1'b0, 8'h00);

        // Lock on the last budgeted byte (timeout 3, counter at 1 with a match).
        lane.hs_sync_timeout = 8'd3;
        cyc(1'b1, 8'h00);
        cyc(1'b1, 8'hB8);
        cyc(1'b1, 8'h12);
        cyc(1'b1, 8'h34);
        cyc(1'b1, 8'h56);
        chk_out("edge.lock", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 8'h00);
        chk_out("edge.b0", 8'h12, 1'b1, 1'b1, 1'b1, 1'b0);

        // Timeout 0: search indefinitely, then still lock.
        cyc(1'b0, 8'h00);
        cyc(1'b0, 8'h00);
        cyc(1'b0, 8'h00);
        lane.hs_sync_timeout = 8'd0;
        seen_err = 1'b0;
        seen_act = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 8'h00);
            seen_err |= lane.sot_err;
            seen_act |= lane.rx_active;
        end
        chk("notmo.no_err", 32'(seen_err), 32'd0);
        chk("notmo.no_act", 32'(seen_act), 32'd0);
        cyc(1'b1, 8'hB8);
        cyc(1'b1, 8'h12);
        cyc(1'b1, 8'h34);
        cyc(1'b1, 8'h56);
        chk("notmo.lock", 32'(lane.rx_active), 32'd1);
        cyc(1'b1, 8'h00);
        chk_out("notmo.b0", 8'h12, 1'b1, 1'b1, 1'b1, 1'b0);

        // Sync received with one bit flipped (0xB9).
        cyc(1'b0, 8'h00);
        cyc(1'b0, 8'h00);
        cyc(1'b0, 8'h00);
        lane.hs_sync_timeout = 8'd6;
        cyc(1'b1, 8'h00);
        cyc(1'b1, 8'h00);
        cyc(1'b1, 8'hB9);
        cyc(1'b1, 8'h12);
        cyc(1'b1, 8'h34);
        cyc(1'b1, 8'h00);
`ifdef DSI_HS_RX_SOT_TOLERANT_EN
        chk_out("tol.lock", 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 8'h00);
        chk_out("tol.b0", 8'h12, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 8'h00);
        chk_out("tol.b1", 8'h34, 1'b1, 1'b0, 1'b1, 1'b0);
`else
        chk_out("strict.search", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'h00);
        chk_out("strict.pre", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'h00);
        chk_out("strict.tmo", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
`endif
        cyc(1'b1, 8'h00);
        chk("b9.no_more_err", 32'(lane.sot_err), 32'd0);

        // Async reset while ACTIVE clears outputs without a clock edge.
        cyc(1'b0, 8'h00);
        cyc(1'b0, 8'h00);
        cyc(1'b0, 8'h00);
        lane.hs_sync_timeout = 8'd0;
        cyc(1'b1, 8'h00);
        cyc(1'b1, 8'hB8);
        cyc(1'b1, 8'h12);
        cyc(1'b1, 8'h34);
        cyc(1'b1, 8'h56);
        cyc(1'b1, 8'h78);
        chk_out("arst.pre", 8'h12, 1'b1, 1'b1, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("arst.now", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b0, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
